// File: rtl/pwm_servo_decoder.sv
// Three-channel servo PWM decoder: per-channel pulse-width capture feeding one shared serial angle converter.
// Optional input glitch filter is built when PWM_DECODER_GLITCH_FILTER_EN is defined.
module pwm_servo_decoder #(
    parameter int FREQ        = 25_000_000,
    parameter int TARGET_FREQ = 10,
    parameter int DC_MIN      = 25_000,
    parameter int DC_MID      = 75_000,
    parameter int DC_MAX      = 125_000,
    parameter int COORD_MAX   = 270,
    parameter int BIT_SIZE    = 10,
    parameter int FILTER_LEN  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pwm_in1,
    input  logic                       pwm_in2,
    input  logic                       pwm_in3,
    output logic signed [BIT_SIZE-1:0] x,
    output logic signed [BIT_SIZE-1:0] y,
    output logic signed [BIT_SIZE-1:0] z,
    output logic [2:0]                 out_valid,
    output logic [2:0]                 no_signal,
    output logic [2:0]                 range_err
);

    localparam int          PERIOD   = FREQ / TARGET_FREQ;
    localparam logic [31:0] TIMEOUT  = 32'(2 * PERIOD);
    localparam logic [31:0] DC_MIN_W = 32'(DC_MIN);
    localparam logic [31:0] DC_MID_W = 32'(DC_MID);
    localparam logic [31:0] DC_MAX_W = 32'(DC_MAX);
    localparam logic [31:0] COORD_W  = 32'(COORD_MAX);
    localparam logic [31:0] DIVISOR  = 32'(DC_MID - DC_MIN);

    typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW} cap_state_e;
    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} conv_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] clamp_width(input logic [31:0] w);
        if (w < DC_MIN_W) return DC_MIN_W;
        if (w > DC_MAX_W) return DC_MAX_W;
        return w;
    endfunction

    function automatic logic signed [BIT_SIZE-1:0] apply_sign(input logic signed [BIT_SIZE-1:0] mag,
                                                              input logic neg);
        return neg ? -mag : mag;
    endfunction

    logic [2:0] pwm_raw;
    logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0] prev_q, prev_d, lvl, rise, fall;

    assign pwm_raw = {pwm_in3, pwm_in2, pwm_in1};

    always_comb begin
        sync1_d = pwm_raw;
        sync2_d = sync1_q;
        prev_d  = lvl;
    end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN + 1);

    logic [2:0]           filt_q, filt_d;
    logic [2:0][FCW-1:0]  fcnt_q, fcnt_d;

    // A new level is taken only after FILTER_LEN consecutive samples disagree with the current one.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            filt_d[i] = filt_q[i];
            fcnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
                else                                   fcnt_d[i] = fcnt_q[i] + FCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;

    cap_state_e  cap_q   [3];
    cap_state_e  cap_d   [3];
    logic [31:0] wcnt_q  [3];
    logic [31:0] wcnt_d  [3];
    logic [31:0] since_q [3];
    logic [31:0] since_d [3];
    logic [31:0] width_q [3];
    logic [31:0] width_d [3];
    logic [2:0]  timeout, latch;
    logic [2:0]  no_signal_q, no_signal_d, range_err_q, range_err_d;

    // Capture FSM next state; a timeout drops any partial capture back to WAIT_RISE.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            timeout[i] = (since_q[i] >= TIMEOUT);
            cap_d[i]   = cap_q[i];
            case (cap_q[i])
                WAIT_RISE: if (rise[i]) cap_d[i] = HIGH;
                HIGH:      if (fall[i]) cap_d[i] = LOW;
                LOW:       if (rise[i]) cap_d[i] = HIGH;
                default:   cap_d[i] = WAIT_RISE;
            endcase
            if (timeout[i] && !rise[i]) cap_d[i] = WAIT_RISE;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            latch[i]       = (cap_q[i] == HIGH) && fall[i] && !timeout[i];
            wcnt_d[i]      = rise[i] ? 32'd1 : ((cap_q[i] == HIGH) ? sat_inc(wcnt_q[i]) : wcnt_q[i]);
            since_d[i]     = rise[i] ? 32'd0 : (timeout[i] ? since_q[i] : since_q[i] + 32'd1);
            width_d[i]     = latch[i] ? clamp_width(wcnt_q[i]) : width_q[i];
            range_err_d[i] = latch[i] && (wcnt_q[i] != clamp_width(wcnt_q[i]));
            no_signal_d[i] = rise[i] ? 1'b0 : (timeout[i] ? 1'b1 : no_signal_q[i]);
        end
    end

    conv_state_e                conv_q, conv_d;
    logic [1:0]                 sel_q, sel_d, pick;
    logic [31:0]                cw_q, cw_d, quo_q, quo_d, rem_q, rem_d, diff;
    logic [32:0]                rem_sh, trial;
    logic [4:0]                 iter_q, iter_d;
    logic                       sign_q, sign_d;
    logic [2:0]                 pend_q, pend_d, pend_clr;
    logic [2:0]                 out_valid_q, out_valid_d;
    logic signed [BIT_SIZE-1:0] x_q, x_d, y_q, y_d, z_q, z_d, qmag, result;

    always_comb begin
        conv_d = conv_q;
        case (conv_q)
            IDLE:    if (|pend_q) conv_d = LOAD;
            LOAD:    conv_d = DIV;
            DIV:     if (iter_q == 5'd31) conv_d = DONE;
            DONE:    conv_d = IDLE;
            default: conv_d = IDLE;
        endcase
    end

    // Converter datapath: width is snapshotted at selection so a fresh capture cannot disturb this pass.
    always_comb begin
        pick        = pend_q[0] ? 2'd0 : (pend_q[1] ? 2'd1 : 2'd2);
        sel_d       = sel_q;
        cw_d        = cw_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        iter_d      = iter_q;
        sign_d      = sign_q;
        pend_clr    = '0;
        out_valid_d = '0;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        diff        = (cw_q >= DC_MID_W) ? cw_q - DC_MID_W : DC_MID_W - cw_q;
        rem_sh      = {rem_q, quo_q[31]};
        trial       = rem_sh - {1'b0, DIVISOR};
        qmag        = quo_q[BIT_SIZE-1:0];
        result      = apply_sign(qmag, sign_q);
        case (conv_q)
            IDLE: begin
                if (|pend_q) begin
                    sel_d          = pick;
                    cw_d           = width_q[pick];
                    pend_clr[pick] = 1'b1;
                end
            end
            LOAD: begin
                quo_d  = diff * COORD_W;
                rem_d  = '0;
                iter_d = '0;
                sign_d = (cw_q < DC_MID_W);
            end
            DIV: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                iter_d = iter_q + 5'd1;
            end
            DONE: begin
                out_valid_d[sel_q] = 1'b1;
                case (sel_q)
                    2'd0:    x_d = result;
                    2'd1:    y_d = result;
                    default: z_d = result;
                endcase
            end
            default: ;
        endcase
        pend_d = (pend_q & ~pend_clr) | latch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                cap_q[i]   <= WAIT_RISE;
                wcnt_q[i]  <= '0;
                since_q[i] <= '0;
                width_q[i] <= '0;
            end
            no_signal_q <= 3'b111;
            range_err_q <= '0;
            conv_q      <= IDLE;
            sel_q       <= '0;
            cw_q        <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            iter_q      <= '0;
            sign_q      <= 1'b0;
            pend_q      <= '0;
            out_valid_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            for (int i = 0; i < 3; i++) begin
                cap_q[i]   <= cap_d[i];
                wcnt_q[i]  <= wcnt_d[i];
                since_q[i] <= since_d[i];
                width_q[i] <= width_d[i];
            end
            no_signal_q <= no_signal_d;
            range_err_q <= range_err_d;
            conv_q      <= conv_d;
            sel_q       <= sel_d;
            cw_q        <= cw_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            iter_q      <= iter_d;
            sign_q      <= sign_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign z         = z_q;
    assign out_valid = out_valid_q;
    assign no_signal = no_signal_q;
    assign range_err = range_err_q;

endmodule
